inst_fetch_requester: RTL and testbench
=======================================

Name: inst_fetch_requester

Overview:
- Initiator side of the instruction-memory request/response interface: the client that drives mem_simulator.
- Generates sequential 16-byte-aligned fetch addresses and issues one outstanding request at a time.
- Captures each 128-bit instruction pack into a small FIFO and hands packs to decode with a valid/ready handshake.
- Supports PC redirect (branch/flush) and a response-timeout watchdog.

Parameters:
- INST_PACK, 128, width of one instruction pack in bits.
- INST_INDEX_SIZE, 32, address width in bits.
- FIFO_DEPTH, 4, number of buffered packs; power of two, at least 2.
- TIMEOUT, 64, cycles to wait for mem_valid before re-issuing.
- RESET_PC, 32'h0000_0000, first fetch address; low 4 bits ignored.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  one-cycle request pulse to memory.
- mem_ready  in  1  memory can accept a request.
- mem_addr  out  INST_INDEX_SIZE  request address; held stable from the req cycle until the response or abort.
- mem_value  in  INST_PACK  returned pack; sampled only when mem_valid=1.
- mem_valid  in  1  one-cycle pulse: mem_value is valid.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  INST_INDEX_SIZE  new fetch address; low 4 bits forced to 0.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head this cycle.
- out_pack  out  INST_PACK  FIFO head pack.
- out_pc  out  INST_INDEX_SIZE  address of the FIFO head pack.
- timeout_err  out  1  sticky flag: at least one timeout occurred since reset.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - mem_req=0, mem_addr=RESET_PC with low 4 bits cleared, out_valid=0, out_pack=0, out_pc=0, timeout_err=0.
  - FIFO empty, FSM in IDLE, fetch_pc=RESET_PC aligned, drop=0, timeout counter=0.
  - Reset mid-request discards everything; no response is awaited after release.
- FSM states IDLE, WAIT.
  - IDLE -> WAIT when mem_ready=1, no redirect_valid, and (fifo_count + 0) < FIFO_DEPTH. In that same cycle: mem_req=1, mem_addr=fetch_pc, timeout counter cleared.
  - WAIT, mem_valid=1 with drop=0: push {mem_addr, mem_value} into FIFO, fetch_pc += 16 (wraps modulo 2^INST_INDEX_SIZE), go to IDLE.
  - WAIT, mem_valid=1 with drop=1: discard the data, clear drop, go to IDLE; fetch_pc is unchanged (it already holds the redirect target).
  - WAIT, counter reaches TIMEOUT-1 without mem_valid: set timeout_err, go to IDLE. The same fetch_pc is re-issued; a late response still arriving is discarded because drop=1 is set.
- mem_req is never asserted in WAIT and never for two consecutive cycles. Minimum issue-to-issue spacing is 2 cycles; with 1-cycle memory latency sustained throughput is 1 pack per 2 cycles.
- Issue uses fifo_count after this cycle's pop. When the FIFO is full and out_ready=1 in the same cycle, a request may still issue.
- Redirect_valid has highest priority:
  - FIFO flushed (out_valid=0 next cycle), fetch_pc=redirect_pc aligned.
  - If in WAIT: go to IDLE with drop=1.
  - No mem_req in the redirect cycle. A pop and a push in the redirect cycle are both cancelled.
- FIFO:
  - Head pops on out_valid&&out_ready.
  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
  - Push never occurs when full, guaranteed by the issue rule.
  - out_pack and out_pc are registered FIFO head values; they are stable while out_valid=1 and out_ready=0.
- mem_value is sampled only on mem_valid. A mem_valid arriving in IDLE with drop=0 is ignored.

Test Plan:
- Basic fetch: RESET_PC=0, memory returns a pack 3 cycles after req, out_ready=1. Required: mem_req pulses with addr 0, 16, 32 in order; out_pc=0, 16, 32; each out_pack matches the memory contents.
- Backpressure: out_ready=0 for 20 cycles. Required: exactly FIFO_DEPTH=4 requests issued (addr 0..48), then no mem_req. Raising out_ready gives 4 pops in consecutive cycles, then fetch resumes at addr 64.
- Redirect in flight: redirect_valid with redirect_pc=32'h107 while in WAIT. Required: FIFO empty next cycle; the stale response is dropped (never appears on out_pack); next mem_req has addr 32'h100; out_pc=32'h100.
- Timeout: memory never asserts mem_valid, TIMEOUT=64. Required: timeout_err=1 after 64 cycles in WAIT; mem_req re-issued with the same addr; a late response to the first request is discarded.
- Reset mid-operation: reset_n low while in WAIT with 2 packs buffered. Required: out_valid=0 immediately (asynchronous); after release the first mem_req addr equals RESET_PC.
- Address wrap: redirect_pc=32'hFFFF_FFF0. Required: next two requests have addr 32'hFFFF_FFF0 then 32'h0000_0000.

Source files
------------

// File: rtl/inst_fetch_requester.sv
// Instruction-fetch initiator: issues one 16-byte-aligned request at a time,
// buffers returned packs in a small FIFO and presents them to decode.
module inst_fetch_requester #(
  parameter int INST_PACK       = 128,
  parameter int INST_INDEX_SIZE = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT         = 64,
  parameter logic [INST_INDEX_SIZE-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic                       mem_req,
  input  logic                       mem_ready,
  output logic [INST_INDEX_SIZE-1:0] mem_addr,
  input  logic [INST_PACK-1:0]       mem_value,
  input  logic                       mem_valid,
  input  logic                       redirect_valid,
  input  logic [INST_INDEX_SIZE-1:0] redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_PACK-1:0]       out_pack,
  output logic [INST_INDEX_SIZE-1:0] out_pc,
  output logic                       timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [INST_INDEX_SIZE-1:0] PC_STEP    = INST_INDEX_SIZE'(16);
  localparam logic [INST_INDEX_SIZE-1:0] ALIGN_MASK = ~INST_INDEX_SIZE'(15);
  localparam logic [INST_INDEX_SIZE-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                     state;
  logic [INST_INDEX_SIZE-1:0] fetch_pc;
  logic                       drop;
  logic [TMO_W-1:0]           tmo_cnt;
  logic                       active;

  logic [INST_INDEX_SIZE-1:0] pc_mem   [FIFO_DEPTH];
  logic [INST_PACK-1:0]       pack_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic [CNT_W-1:0]           count;

  logic                       pop;
  logic                       push;
  logic                       issue;
  logic                       tmo_hit;
  logic [CNT_W-1:0]           count_after_pop;
  logic [CNT_W-1:0]           count_next;
  logic [PTR_W-1:0]           rd_next;
  logic [INST_INDEX_SIZE-1:0] head_pc;
  logic [INST_PACK-1:0]       head_pack;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no latch can be inferred on any path.
  always_comb begin
    pop             = out_valid && out_ready && !redirect_valid;
    push            = (state == S_WAIT) && mem_valid && !drop && !redirect_valid;
    count_after_pop = count - CNT_W'(pop);
    count_next      = count_after_pop + CNT_W'(push);
    rd_next         = rd_ptr + PTR_W'(pop);
    // Issue looks at occupancy after this cycle's pop, so a full FIFO being
    // drained can still launch the next request.
    issue   = active && (state == S_IDLE) && mem_ready && !redirect_valid &&
              (count_after_pop < DEPTH_CNT);
    tmo_hit = (state == S_WAIT) && !mem_valid && (tmo_cnt == TMO_LAST);
    head_pc   = pc_mem[rd_next];
    head_pack = pack_mem[rd_next];
    if (count_after_pop == '0) begin
      head_pc   = fetch_pc;
      head_pack = mem_value;
    end
  end

  assign mem_req  = issue;
  assign mem_addr = fetch_pc;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC_ALIGNED;
      drop        <= 1'b0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      active      <= 1'b0;
    end else begin
      active <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ALIGN_MASK;
        state    <= S_IDLE;
        // A response arriving in this very cycle has already been consumed.
        if (state == S_WAIT) drop <= mem_valid ? drop : 1'b1;
        else                 drop <= drop && !mem_valid;
      end else begin
        case (state)
          S_IDLE: begin
            if (mem_valid && drop) drop <= 1'b0;
            if (issue) begin
              state   <= S_WAIT;
              tmo_cnt <= '0;
            end
          end
          S_WAIT: begin
            if (mem_valid) begin
              if (!drop) fetch_pc <= fetch_pc + PC_STEP;
              drop  <= 1'b0;
              state <= S_IDLE;
            end else if (tmo_hit) begin
              timeout_err <= 1'b1;
              drop        <= 1'b1;
              state       <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // NOTE: the pack storage is deliberately left without reset; count and the
  // valid flag decide what is meaningful, and this keeps the array as plain RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      pack_mem[wr_ptr] <= mem_value;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_pack  <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      rd_ptr    <= rd_next;
      wr_ptr    <= wr_ptr + PTR_W'(push);
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (count_next != '0) begin
        out_pack <= head_pack;
        out_pc   <= head_pc;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_requester.sv
// Bench for inst_fetch_requester: one-outstanding memory model, directed
// scenarios plus a randomized phase, with a scoreboard of expected packs.
module tb_inst_fetch_requester;

  localparam int PW    = 128;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_req;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_value = '0;
  logic          mem_valid = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pack;
  logic [AW-1:0] out_pc;
  logic          timeout_err;

  inst_fetch_requester #(
    .INST_PACK(PW), .INST_INDEX_SIZE(AW), .FIFO_DEPTH(DEPTH),
    .TIMEOUT(TMO), .RESET_PC(32'h0000_0000)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_value(mem_value), .mem_valid(mem_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pack(out_pack), .out_pc(out_pc), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed function of the address.
  function automatic logic [PW-1:0] pack_of(input logic [AW-1:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a, a * 32'd3 + 32'd1, {a[15:0], a[31:16]}};
  endfunction

  // ---------------- memory model: one outstanding request ----------------
  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } resp_t;

  resp_t         pending[$];
  logic [AW-1:0] req_log[$];
  int            cyc = 0;
  int            lat = 3;
  bit            ready_en = 1'b1;
  int            last_req_cyc = 0;
  bit            prev_req = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_req = 1'b0;
    end else if (mem_req) begin
      check("no_back_to_back_req", {127'b0, prev_req}, '0);
      req_log.push_back(mem_addr);
      last_req_cyc = cyc;
      pending.push_back('{cyc + lat, mem_addr});
      prev_req = 1'b1;
    end else begin
      prev_req = 1'b0;
    end
  end

  always @(posedge clock) begin
    resp_t r;
    #1;
    cyc++;
    mem_valid = 1'b0;
    mem_value = {$urandom, $urandom, $urandom, $urandom};
    if (!reset_n) begin
      pending.delete();
    end else if (pending.size() > 0 && pending[0].due <= cyc) begin
      r = pending.pop_front();
      mem_valid = 1'b1;
      mem_value = pack_of(r.addr);
    end
    mem_ready = ready_en && (pending.size() == 0);
  end

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_tail;
  int            pops = 0;

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd16;
    end
  endtask

  task automatic restart(input logic [AW-1:0] pc);
    exp_q.delete();
    exp_tail = {pc[AW-1:4], 4'h0};
    top_up();
  endtask

  bit            hold_v = 1'b0;
  logic [AW-1:0] hold_pc;
  logic [PW-1:0] hold_pack;

  always @(negedge clock) begin
    logic [AW-1:0] e;
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && !redirect_valid) begin
        check("held_pc", out_pc, hold_pc);
        check("held_pack", out_pack, hold_pack);
      end
      if (out_valid && out_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e);
          check("out_pack", out_pack, pack_of(e));
        end
        pops++;
      end
      hold_v    = out_valid && !out_ready && !redirect_valid;
      hold_pc   = out_pc;
      hold_pack = out_pack;
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
      top_up();
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    tick(3);
    req_log.delete();
    reset_n = 1'b1;
    restart(32'h0);
  endtask

  task automatic wait_reqs(input int n, input int budget, input string name);
    int k = 0;
    while (req_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, {127'b0, req_log.size() >= n}, 1);
  endtask

  task automatic redirect(input logic [AW-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    restart(pc);
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int base;
    int n0;
    int c0;
    logic [AW-1:0] a0;

    // Reset state
    tick(3);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pack", out_pack, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_timeout_err", timeout_err, 0);

    // Basic fetch, 3-cycle memory
    lat = 3;
    out_ready = 1'b1;
    do_reset();
    base = pops;
    wait_reqs(3, 40, "basic_req_bound");
    check("basic_addr0", req_log[0], 32'h0);
    check("basic_addr1", req_log[1], 32'h10);
    check("basic_addr2", req_log[2], 32'h20);
    tick(20);
    check("basic_pops", {127'b0, pops - base >= 3}, 1);

    // Backpressure
    out_ready = 1'b0;
    lat = 1;
    do_reset();
    tick(20);
    check("bp_req_count", req_log.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) check("bp_addr", req_log[i], 32'(16 * i));
    check("bp_out_valid", out_valid, 1);
    base = pops;
    out_ready = 1'b1;
    tick(4);
    check("bp_four_pops", pops - base, 4);
    wait_reqs(DEPTH + 1, 20, "bp_resume_bound");
    check("bp_resume_addr", req_log[DEPTH], 32'h40);

    // Redirect while a request is in flight
    lat = 6;
    do_reset();
    wait_reqs(1, 10, "redir_req_bound");
    tick(2);
    n0 = req_log.size();
    base = pops;
    redirect(32'h107);
    check("redir_flush", out_valid, 0);
    wait_reqs(n0 + 1, 30, "redir_new_req_bound");
    check("redir_addr", req_log[n0], 32'h100);
    tick(30);
    check("redir_pops", {127'b0, pops > base}, 1);

    // Timeout with a late response
    lat = 200;
    do_reset();
    wait_reqs(1, 10, "tmo_req_bound");
    c0 = last_req_cyc;
    a0 = req_log[0];
    while (cyc < c0 + TMO) tick();
    check("tmo_not_yet", timeout_err, 0);
    tick();
    check("tmo_flag", timeout_err, 1);
    lat = 3;
    wait_reqs(2, 250, "tmo_reissue_bound");
    check("tmo_reissue_addr", req_log[1], a0);
    base = pops;
    tick(20);
    check("tmo_pops", {127'b0, pops > base}, 1);
    check("tmo_sticky", timeout_err, 1);

    // Reset mid-operation with two packs buffered
    out_ready = 1'b0;
    lat = 3;
    do_reset();
    wait_reqs(3, 40, "rstmid_req_bound");
    check("rstmid_buffered", out_valid, 1);
    #1 reset_n = 1'b0;
    #1 check("rstmid_async_clear", out_valid, 0);
    tick(3);
    req_log.delete();
    reset_n = 1'b1;
    restart(32'h0);
    wait_reqs(1, 10, "rstmid_req_after_bound");
    check("rstmid_first_addr", req_log[0], 32'h0);
    out_ready = 1'b1;
    tick(20);

    // Address wrap
    lat = 2;
    n0 = req_log.size();
    redirect(32'hFFFF_FFF0);
    n0 = req_log.size();
    wait_reqs(n0 + 2, 40, "wrap_req_bound");
    check("wrap_addr0", req_log[n0], 32'hFFFF_FFF0);
    check("wrap_addr1", req_log[n0 + 1], 32'h0);
    tick(20);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      lat       = $urandom_range(1, 5);
      ready_en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 63) == 0) redirect($urandom);
      else tick();
    end
    out_ready = 1'b1;
    ready_en  = 1'b1;
    base = pops;
    tick(30);
    check("rand_drain_pops", {127'b0, pops > base}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks run", tests);
    $fatal(1, "watchdog");
  end

endmodule
